// File: rtl/ysyx_22040759_divider_pkg.sv
// Shared types, widths and helpers for the iterative RV64M divider.
// Operand extension and conditional negation are used by the top module.
package ysyx_22040759_divider_pkg;

    localparam int XLEN      = 64;
    localparam int WORD_ITER = 32;
    localparam int CNT_W     = $clog2(XLEN);

    localparam logic [XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] sext32(
        input logic [31:0] v
    );
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] ext32(
        input logic [31:0] v,
        input logic        sgn
    );
        return sgn ? sext32(v) : {32'b0, v};
    endfunction

    function automatic logic [XLEN-1:0] cneg(
        input logic [XLEN-1:0] v,
        input logic            neg
    );
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ysyx_22040759_div_step.sv
// One restoring shift-subtract step: shifts in the next dividend bit and
// subtracts the divisor when it fits, producing one quotient bit.
module ysyx_22040759_div_step
    import ysyx_22040759_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_i < dvs_i always holds, so the shifted value fits in XLEN+1 bits
    // and the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {1'b0, dvs_i};
        q_o     = ~diff[XLEN];
        rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_22040759_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// One quotient bit per BUSY cycle, then one cycle for sign fixup.
module ysyx_22040759_divider
    import ysyx_22040759_divider_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_dividend,
    input  logic [XLEN-1:0] req_divisor,
    input  logic            req_signed,
    input  logic            req_word,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_quotient,
    output logic [XLEN-1:0] resp_remainder
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fix_q;
    logic             word_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  remd_q;

    logic [XLEN-1:0]  a_eff;
    logic [XLEN-1:0]  b_eff;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic [XLEN-1:0]  sp_quot_d;
    logic [XLEN-1:0]  sp_rem_d;
    logic [XLEN-1:0]  dvd_init_d;
    logic [CNT_W-1:0] cnt_init_d;

    logic [XLEN-1:0]  step_rem;
    logic             step_bit;
    logic [XLEN-1:0]  q_fix;
    logic [XLEN-1:0]  r_fix;
    logic [XLEN-1:0]  quot_d;
    logic [XLEN-1:0]  remd_d;

    // Operand preparation and special-case detection at the effective width.
    always_comb begin
        a_eff = req_dividend;
        b_eff = req_divisor;
        if (req_word) begin
            a_eff = ext32(req_dividend[31:0], req_signed);
            b_eff = ext32(req_divisor[31:0], req_signed);
        end
        a_neg    = req_signed & a_eff[XLEN-1];
        b_neg    = req_signed & b_eff[XLEN-1];
        a_mag    = cneg(a_eff, a_neg);
        b_mag    = cneg(b_eff, b_neg);
        div_zero = (b_eff == '0);
        overflow = req_signed && (b_eff == '1)
                   && (a_eff == (req_word ? MIN_W : MIN_D));
        special  = div_zero | overflow;

        sp_quot_d = div_zero ? '1 : a_eff;
        sp_rem_d  = div_zero ? a_eff : '0;
        if (req_word) begin
            sp_quot_d = sext32(sp_quot_d[31:0]);
            sp_rem_d  = sext32(sp_rem_d[31:0]);
        end

        // Word operands sit in the top half so the step always eats bit 63.
        dvd_init_d = req_word ? {a_mag[31:0], 32'b0} : a_mag;
        cnt_init_d = req_word ? CNT_W'(WORD_ITER - 1) : CNT_W'(XLEN - 1);
    end

    ysyx_22040759_div_step u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[XLEN-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    always_comb begin
        q_fix  = cneg(dvd_q, qneg_q);
        r_fix  = cneg(rem_q, rneg_q);
        quot_d = word_q ? sext32(q_fix[31:0]) : q_fix;
        remd_d = word_q ? sext32(r_fix[31:0]) : r_fix;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            word_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            fix_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    fix_q <= 1'b0;
                    if (req_valid) begin
                        if (special) begin
                            quot_q  <= sp_quot_d;
                            remd_q  <= sp_rem_d;
                            state_q <= S_DONE;
                        end else begin
                            word_q  <= req_word;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            rem_q   <= '0;
                            dvd_q   <= dvd_init_d;
                            dvs_q   <= b_mag;
                            cnt_q   <= cnt_init_d;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!fix_q) begin
                        rem_q <= step_rem;
                        dvd_q <= {dvd_q[XLEN-2:0], step_bit};
                        cnt_q <= cnt_q - CNT_W'(1);
                        fix_q <= (cnt_q == '0);
                    end else begin
                        quot_q  <= quot_d;
                        remd_q  <= remd_d;
                        fix_q   <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_DONE);
    assign resp_quotient  = quot_q;
    assign resp_remainder = remd_q;

endmodule

// File: tb/tb_ysyx_22040759_divider.sv
// Self-checking bench for the iterative RV64M divider.
// Vector table feeds a scoreboard queue; control corners are hand-written.
module tb_ysyx_22040759_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic        req_signed;
    logic        req_word;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_quotient;
    logic [63:0] resp_remainder;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        w;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    vec_t sb[$];

    ysyx_22040759_divider dut (
        .clock          (clk),
        .reset          (reset),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_signed     (req_signed),
        .req_word       (req_word),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v, input bit track);
        @(negedge clk);
        req_dividend = v.a;
        req_divisor  = v.b;
        req_signed   = v.s;
        req_word     = v.w;
        req_valid    = 1'b1;
        chk("req_ready_before_hs", 64'(req_ready), 64'd1);
        @(posedge clk);
        if (track) sb.push_back(v);
        #1;
        req_valid    = 1'b0;
        req_dividend = {$urandom, $urandom};
        req_divisor  = {$urandom, $urandom};
        req_signed   = 1'($urandom);
        req_word     = 1'($urandom);
    endtask

    task automatic collect(input string tag, input int hold);
        int   lat;
        bit   got;
        vec_t e;
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            got = resp_valid;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no resp_valid expected one", tag);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got response expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quot"}, resp_quotient, e.q);
            chk({tag, "_rem"}, resp_remainder, e.r);
            chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
            chk({tag, "_ready_done"}, 64'(req_ready), 64'd0);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
                chk({tag, "_hold_quot"}, resp_quotient, e.q);
                chk({tag, "_hold_rem"}, resp_remainder, e.r);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            chk({tag, "_drain_valid"}, 64'(resp_valid), 64'd0);
            chk({tag, "_drain_ready"}, 64'(req_ready), 64'd1);
        end
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        chk({tag, "_no_resp"}, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65};
        vecs[1]  = '{-64'sd7, 64'd2, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[2]  = '{64'd7, -64'sd2, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
        vecs[3]  = '{64'd42, 64'd0, 1'b0, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1};
        vecs[4]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1};
        vecs[5]  = '{64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 1};
        vecs[6]  = '{64'hFFFF_FFFF_0000_0010, 64'd3, 1'b0, 1'b1,
                     64'd5, 64'd1, 33};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[8]  = '{64'h0000_0000_8000_0000, 64'd1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 64'd0, 33};
        vecs[9]  = '{64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000,
                     1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0005, 1};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b0, 64'd1, 64'd0, 65};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0,
                     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 65};
        vecs[12] = '{64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0,
                     64'hC000_0000_0000_0000, 64'd0, 65};
        vecs[13] = '{-64'sd100, -64'sd7, 1'b1, 1'b0,
                     64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[14] = '{-64'sd5, 64'd0, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1};
        vecs[15] = '{64'd5, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 33};
        vecs[16] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     1'b0, 1'b0, 64'd0, 64'h8000_0000_0000_0000, 65};

        reset        = 1'b1;
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = 1'b0;
        req_word     = 1'b0;
        resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_quot", resp_quotient, 64'd0);
        chk("rst_rem", resp_remainder, 64'd0);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], 1'b1);
            collect($sformatf("v%0d", i), (i == 0 || i == 3) ? 10 : 0);
        end

        // Flush in the 20th BUSY cycle kills the operation.
        issue(vecs[0], 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy_ready", 64'(req_ready), 64'd1);
        chk("flush_busy_valid", 64'(resp_valid), 64'd0);
        watch_quiet("flush_busy", 80);

        // Flush with a request in IDLE must not accept it.
        @(negedge clk);
        req_dividend = 64'd42;
        req_divisor  = 64'd0;
        req_signed   = 1'b0;
        req_word     = 1'b0;
        req_valid    = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_ready", 64'(req_ready), 64'd1);
        watch_quiet("flush_idle", 5);

        // Flush discards a result held in DONE.
        issue(vecs[3], 1'b0);
        @(posedge clk);
        #1;
        chk("flush_done_pre_valid", 64'(resp_valid), 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_valid", 64'(resp_valid), 64'd0);
        chk("flush_done_ready", 64'(req_ready), 64'd1);

        // Reset during BUSY returns everything to reset values.
        issue(vecs[1], 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstbusy_ready", 64'(req_ready), 64'd1);
        chk("rstbusy_valid", 64'(resp_valid), 64'd0);
        chk("rstbusy_quot", resp_quotient, 64'd0);
        chk("rstbusy_rem", resp_remainder, 64'd0);
        watch_quiet("rstbusy", 80);

        issue(vecs[6], 1'b1);
        collect("recover", 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_divider.md
Name: ysyx_22040759_divider

Overview:
- Multi-cycle iterative radix-2 restoring divider for RV64M: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the combinational ALU in the EXU and takes over division off the critical path.
- Execute stage is the requester; this block is the responder over a valid/ready request channel and a valid/ready result channel.
- Produces both quotient and remainder; the EXU selects one.

Parameters:
- XLEN, 64, operand and result width; only 64 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline kill; aborts any operation in flight
- req_valid  in  1  request present
- req_ready  out  1  divider can accept a request
- req_dividend  in  64  operand a (rs1)
- req_divisor  in  64  operand b (rs2)
- req_signed  in  1  1 = DIV/REM family, 0 = unsigned
- req_word  in  1  1 = *W variant: use bits [31:0], sign-extend results
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_quotient  out  64  quotient; already sign-extended in word mode
- resp_remainder  out  64  remainder; already sign-extended in word mode

Behaviour:
- Clocking and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_quotient = 0, resp_remainder = 0.
- Reset mid-operation returns to IDLE next edge; no response is emitted.
- States:
  - IDLE: req_ready = 1. A handshake (req_valid & req_ready) latches the operands and mode.
  - Special case at handshake: go to DONE with the result computed directly.
  - Otherwise: go to BUSY with iteration counter = N−1, where N = 32 if req_word else 64.
  - BUSY: req_ready = 0. Each cycle does one shift-subtract step on the |dividend| / |divisor| magnitudes. When the counter reaches 0, apply sign fixup and go to DONE.
  - DONE: resp_valid = 1 and outputs stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready = 0 in DONE).
- Latency, handshake at cycle 0:
  - normal: resp_valid at cycle N+1 (65 for 64-bit, 33 for word)
  - special case: resp_valid at cycle 1
- Operand prep in word mode: operands are the low 32 bits, sign- or zero-extended per req_signed.
- Final results in word mode: bits [31:0] of quotient and remainder are sign-extended to 64, including DIVUW/REMUW, per the RV64 spec.
- Signed arithmetic:
  - Magnitudes are used during iteration.
  - Quotient negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, evaluated at the effective width:
  - Divisor == 0: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (dividend = most negative value, divisor = -1): quotient = dividend, remainder = 0.
- flush:
  - Wins over every other event in any state.
  - Next state IDLE, resp_valid deasserts next cycle.
  - A result in DONE is discarded.
  - flush together with req_valid in IDLE does not accept the request.
- Backpressure: DONE holds indefinitely while resp_ready = 0; outputs must not change.
- Stability: req_* need only be valid in the handshake cycle; the block keeps its own copies.

Decomposition:
- Shared package/define file: XLEN, state encoding (IDLE/BUSY/DONE), word-mode iteration count 32.
- Optional sub-module ysyx_22040759_div_step: combinational single shift-subtract step (partial remainder, quotient bit).
- The FSM, counter and sign fixup stay in the top module.

Test Plan:
- DIVU 100 / 7, req_word = 0 -> quotient 14, remainder 2; resp_valid exactly 65 cycles after the handshake.
- DIV -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF. REM 7 / -2 -> remainder 1, quotient 0xFFFF_FFFF_FFFF_FFFD.
- Divide by zero, DIVU 42 / 0 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 42, resp_valid at cycle 1.
- Signed overflow, DIV 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0, cycle 1.
- Word mode:
  - DIVW 0x1234_5678_8000_0000 / 0xFFFF_FFFF -> quotient 0xFFFF_FFFF_8000_0000, remainder 0.
  - DIVUW 0xFFFF_FFFF_0000_0010 / 3 -> quotient 5, remainder 1, latency 33.
- Control:
  - flush at cycle 20 of BUSY -> resp_valid never rises and req_ready = 1 the next cycle.
  - resp_ready held low 10 cycles in DONE -> outputs stable; reset asserted in BUSY -> IDLE with all outputs at their reset values.
